// File: rtl/binarize_pkg.sv
// Shared types and helpers for the pixel binarizer.
//   mode_t        : per-frame binarization mode (latched on SOF)
//   stats_state_t : frame statistics FSM states
//   luma()        : (R + 2G + B) >> 2, width-generic. Callers zero-extend their
//                   channels to LUMA_MAX_W and truncate the result to their own
//                   width, so one function serves any DATA_W up to LUMA_MAX_W.
package binarize_pkg;

    typedef enum logic [1:0] {
        BYPASS     = 2'd0,
        CHAN_FIXED = 2'd1,
        LUMA_FIXED = 2'd2,
        LUMA_AUTO  = 2'd3
    } mode_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } stats_state_t;

    localparam int LUMA_MAX_W = 32;

    // Two guard bits hold R + 2G + B without overflow; after >> 2 the result
    // always fits back into the channel width.
    function automatic logic [LUMA_MAX_W+1:0] luma(
        input logic [LUMA_MAX_W-1:0] r,
        input logic [LUMA_MAX_W-1:0] g,
        input logic [LUMA_MAX_W-1:0] b
    );
        logic [LUMA_MAX_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum >> 2;
    endfunction

endpackage

// File: rtl/frame_minmax_tracker.sv
// Frame luma statistics: tracks min/max luma over each frame and publishes
// the midpoint of the previous frame as the auto threshold.
// Ports:
//   iCLK, iRST_n : clock, async active-low reset
//   iValid, iSOF : pixel qualifier and start-of-frame marker (SOF only counts
//                  when iValid=1)
//   iLuma        : luma of the current input pixel
//   oThrAuto     : auto threshold, DEF_THR until a full frame has been seen
//
// state    | meaning
// WAIT_SOF | no frame started since reset; pixels are not measured
// ACCUM    | accumulating min/max for the current frame
module frame_minmax_tracker
    import binarize_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int DEF_THR = 2**(DATA_W-1)
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iValid,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iLuma,
    output logic [DATA_W-1:0] oThrAuto
);

    stats_state_t state, next_state;

    logic [DATA_W-1:0] min_luma;
    logic [DATA_W-1:0] max_luma;
    logic [DATA_W-1:0] thr_auto;
    logic [DATA_W:0]   mid_sum;
    logic [DATA_W-1:0] midpoint;

    logic load;
    logic publish;
    logic track;

    // One extra bit so min + max never wraps before halving.
    assign mid_sum  = {1'b0, min_luma} + {1'b0, max_luma};
    assign midpoint = DATA_W'(mid_sum >> 1);
    assign oThrAuto = thr_auto;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= WAIT_SOF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        publish    = 1'b0;
        track      = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (iValid && iSOF) begin
                    load       = 1'b1;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (iValid && iSOF) begin
                    publish = 1'b1;
                    load    = 1'b1;
                end else if (iValid) begin
                    track = 1'b1;
                end
            end
            default: next_state = WAIT_SOF;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            min_luma <= '1;
            max_luma <= '0;
            thr_auto <= DATA_W'(DEF_THR);
        end else begin
            if (publish) begin
                thr_auto <= midpoint;
            end
            if (load) begin
                min_luma <= iLuma;
                max_luma <= iLuma;
            end else if (track) begin
                if (iLuma < min_luma) begin
                    min_luma <= iLuma;
                end
                if (iLuma > max_luma) begin
                    max_luma <= iLuma;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_binarizer.sv
// Pipelined RGB binarizer between demosaic and frame buffer writer.
// Each valid pixel becomes full-scale or zero per channel using the mode
// latched at the frame's SOF pixel: bypass, per-channel fixed threshold,
// luma fixed threshold, or luma auto threshold (midpoint of previous frame).
// Ports:
//   iCLK, iRST_n              : clock, async active-low reset
//   iValid, iSOF              : pixel valid, start of frame (with iValid)
//   iRed, iGreen, iBlue       : input channels
//   iMode                     : requested mode, taken only on SOF pixels
//   iThreshold                : fixed threshold, used live (not latched)
//   oValid                    : output valid, iValid delayed by two cycles
//   oRed, oGreen, oBlue       : binarized (or bypassed) channels
//   oThreshold                : threshold used for the pixel on the outputs
module pixel_binarizer
    import binarize_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int DEF_THR = 2**(DATA_W-1)
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iValid,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic [1:0]        iMode,
    input  logic [DATA_W-1:0] iThreshold,
    output logic              oValid,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic [DATA_W-1:0] oThreshold
);

    localparam logic [DATA_W-1:0] FULL = '1;

    mode_t             frame_mode;
    mode_t             pix_mode;
    logic [DATA_W-1:0] pix_luma;
    logic [DATA_W-1:0] thr_auto;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_red;
    logic [DATA_W-1:0] s1_green;
    logic [DATA_W-1:0] s1_blue;
    logic [DATA_W-1:0] s1_luma;
    mode_t             s1_mode;

    logic [DATA_W-1:0] thr_sel;
    logic [DATA_W-1:0] nxt_red;
    logic [DATA_W-1:0] nxt_green;
    logic [DATA_W-1:0] nxt_blue;
    logic [DATA_W-1:0] luma_bin;

    assign pix_luma = DATA_W'(luma(LUMA_MAX_W'(iRed), LUMA_MAX_W'(iGreen),
                                   LUMA_MAX_W'(iBlue)));

    // The SOF pixel already belongs to the new frame, so it takes the
    // incoming mode rather than the one still held in the latch.
    assign pix_mode = (iValid && iSOF) ? mode_t'(iMode) : frame_mode;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            frame_mode <= BYPASS;
        end else if (iValid && iSOF) begin
            frame_mode <= mode_t'(iMode);
        end
    end

    frame_minmax_tracker #(
        .DATA_W  (DATA_W),
        .DEF_THR (DEF_THR)
    ) u_tracker (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .iValid   (iValid),
        .iSOF     (iSOF),
        .iLuma    (pix_luma),
        .oThrAuto (thr_auto)
    );

    // Stage 1: capture channels, luma and frame mode. Data holds when idle.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1_valid <= 1'b0;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s1_luma  <= '0;
            s1_mode  <= BYPASS;
        end else begin
            s1_valid <= iValid;
            if (iValid) begin
                s1_red   <= iRed;
                s1_green <= iGreen;
                s1_blue  <= iBlue;
                s1_luma  <= pix_luma;
                s1_mode  <= pix_mode;
            end
        end
    end

    // thr_auto is read one cycle after the SOF pixel updated it, so the SOF
    // pixel is judged against the freshly published midpoint.
    always_comb begin
        thr_sel   = (s1_mode == LUMA_AUTO) ? thr_auto : iThreshold;
        luma_bin  = (s1_luma > thr_sel) ? FULL : '0;
        nxt_red   = luma_bin;
        nxt_green = luma_bin;
        nxt_blue  = luma_bin;
        case (s1_mode)
            BYPASS: begin
                nxt_red   = s1_red;
                nxt_green = s1_green;
                nxt_blue  = s1_blue;
            end
            CHAN_FIXED: begin
                nxt_red   = (s1_red   > thr_sel) ? FULL : '0;
                nxt_green = (s1_green > thr_sel) ? FULL : '0;
                nxt_blue  = (s1_blue  > thr_sel) ? FULL : '0;
            end
            default: ;
        endcase
    end

    // Stage 2: registered outputs.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oValid     <= 1'b0;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oThreshold <= DATA_W'(DEF_THR);
        end else begin
            oValid <= s1_valid;
            if (s1_valid) begin
                oRed       <= nxt_red;
                oGreen     <= nxt_green;
                oBlue      <= nxt_blue;
                oThreshold <= thr_sel;
            end
        end
    end

endmodule

// File: tb/tb_pixel_binarizer.sv
// Scoreboard bench for pixel_binarizer: directed pixels push hand-computed
// expectations (channels, threshold, due cycle); a monitor pops and compares
// on every oValid.
module tb_pixel_binarizer;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic         sof;
    logic [W-1:0] red, green, blue, thr;
    logic [1:0]   mode;
    logic         o_valid;
    logic [W-1:0] o_red, o_green, o_blue, o_thr;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic [W-1:0] t;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    pixel_binarizer #(.DATA_W(W)) dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iValid     (valid),
        .iSOF       (sof),
        .iRed       (red),
        .iGreen     (green),
        .iBlue      (blue),
        .iMode      (mode),
        .iThreshold (thr),
        .oValid     (o_valid),
        .oRed       (o_red),
        .oGreen     (o_green),
        .oBlue      (o_blue),
        .oThreshold (o_thr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic send(input int r, input int g, input int b, input bit s,
                        input int m, input int er, input int eg, input int eb,
                        input int et);
        exp_t e;
        valid = 1'b1;
        sof   = s;
        mode  = m[1:0];
        red   = r[W-1:0];
        green = g[W-1:0];
        blue  = b[W-1:0];
        e.r   = er[W-1:0];
        e.g   = eg[W-1:0];
        e.b   = eb[W-1:0];
        e.t   = et[W-1:0];
        e.due = cyc + 2;
        q.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every valid output must match the oldest pending expectation
    // and arrive exactly on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL spurious_valid: oValid=1 at cycle %0d, expected no pixel", cyc);
                end else begin
                    e = q.pop_front();
                    if (o_red == e.r && o_green == e.g && o_blue == e.b &&
                        o_thr == e.t && cyc == e.due) begin
                        n_pass++;
                    end else begin
                        $display("FAIL pixel: got %0d/%0d/%0d thr %0d cyc %0d, expected %0d/%0d/%0d thr %0d cyc %0d",
                                 o_red, o_green, o_blue, o_thr, cyc,
                                 e.r, e.g, e.b, e.t, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        sof   = 1'b0;
        red   = '0;
        green = '0;
        blue  = '0;
        mode  = 2'd0;
        thr   = 12'd100;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ovalid", int'(o_valid), 0);
        check("reset_ored", int'(o_red), 0);
        check("reset_othr", int'(o_thr), 2048);
        rst_n = 1'b1;

        // Bypass
        send(123, 4000, 7, 1, 0, 123, 4000, 7, 100);
        idle(2);

        // Per-channel fixed threshold
        thr = 12'd2048;
        send(2049, 2048, 0, 1, 1, 4095, 0, 0, 2048);
        send(0, 4095, 2048, 0, 1, 0, 4095, 0, 2048);
        idle(2);

        // Luma fixed threshold: lumas 1002, 1000, 1000 (truncated), 4095
        thr = 12'd1000;
        send(1000, 1004, 1000, 1, 2, 4095, 4095, 4095, 1000);
        send(1000, 1000, 1000, 0, 2, 0, 0, 0, 1000);
        send(1001, 1000, 1000, 0, 2, 0, 0, 0, 1000);
        send(4095, 4095, 4095, 0, 2, 4095, 4095, 4095, 1000);
        idle(2);

        // Mode change mid-frame is deferred to the next SOF; gap in iValid
        thr = 12'd2048;
        send(3000, 1000, 2049, 1, 1, 4095, 0, 4095, 2048);
        send(100, 3000, 2048, 0, 0, 0, 4095, 0, 2048);
        idle(1);
        send(2049, 2049, 2049, 0, 0, 4095, 4095, 4095, 2048);
        send(5, 6, 7, 1, 0, 5, 6, 7, 2048);

        // Reset mid-frame with two pixels in flight
        send(11, 22, 33, 0, 0, 11, 22, 33, 2048);
        send(44, 55, 66, 0, 0, 44, 55, 66, 2048);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midreset_ovalid", int'(o_valid), 0);
        check("midreset_ored", int'(o_red), 0);
        check("midreset_othr", int'(o_thr), 2048);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        check("postreset_othr", int'(o_thr), 2048);

        // Pre-SOF pixel: bypass (mode reset), not measured
        thr = 12'd10;
        send(4000, 4000, 4000, 0, 3, 4000, 4000, 4000, 10);
        idle(1);

        // Auto frame 1: lumas 100, 900, 400 vs default 2048
        send(100, 100, 100, 1, 3, 0, 0, 0, 2048);
        send(900, 900, 900, 0, 3, 0, 0, 0, 2048);
        send(400, 400, 400, 0, 3, 0, 0, 0, 2048);
        // Frame 2: threshold (100+900)/2 = 500
        send(600, 600, 600, 1, 3, 4095, 4095, 4095, 500);
        send(500, 500, 500, 0, 3, 0, 0, 0, 500);
        send(501, 501, 501, 0, 3, 4095, 4095, 4095, 500);
        // Frame 3: threshold (500+600)/2 = 550, single-pixel frame
        send(550, 550, 550, 1, 3, 0, 0, 0, 550);
        // Frame 4: single-pixel frame 3 gives threshold 550
        send(700, 700, 700, 1, 3, 4095, 4095, 4095, 550);
        // Frame 5: threshold 700, equal luma is not above it
        send(700, 700, 700, 1, 3, 0, 0, 0, 700);

        idle(4);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
